// File: rtl/csla_div16_pkg.sv
// -----------------------------------------------------------------------------
// csla_div_pkg
// Shared definitions for the carry-select restoring divider:
//   state_t    - divider FSM states
//   GROUP      - width of one borrow-select subtractor group
//   cnt_width  - iteration counter width able to hold the value WIDTH
// -----------------------------------------------------------------------------
package csla_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned GROUP = 4;

    // Counter must reach WIDTH itself without wrapping: ceil(log2(WIDTH+1)).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/csla_div16_if.sv
// -----------------------------------------------------------------------------
// csla_div16_if
// Start/done handshake bundle for the divider.
//   start, dividend, divisor        : requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                     : divider -> requester
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface csla_div16_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/csla_div16_group4_sub.sv
// -----------------------------------------------------------------------------
// group4_sub
// One 4-bit borrow-select subtractor group.
//   i_a, i_b : operands (difference is i_a - i_b - i_bin)
//   i_bin    : borrow-in from the less significant group (mux select)
//   o_diff   : selected 4-bit difference
//   o_bout   : selected borrow-out to the next group
// Both candidate results are formed ahead of the borrow arriving; the
// borrow-in=1 candidate is a decrement of the borrow-in=0 ripple result.
// -----------------------------------------------------------------------------
module group4_sub
    import csla_div_pkg::*;
(
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_bin,
    output logic [GROUP-1:0] o_diff,
    output logic             o_bout
);

    logic             w_br [0:GROUP];
    logic [GROUP-1:0] w_d0;
    logic [GROUP-1:0] w_d1;
    logic             w_b1;

    assign w_br[0] = 1'b0;

    for (genvar i = 0; i < GROUP; i++) begin : g_rip
        assign w_d0[i]   = i_a[i] ^ i_b[i] ^ w_br[i];
        assign w_br[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_br[i]);
    end

    // a - b - 1 borrows iff a - b already borrowed or a - b is exactly zero.
    assign w_d1 = w_d0 - GROUP'(1);
    assign w_b1 = w_br[GROUP] | (w_d0 == '0);

    assign o_diff = i_bin ? w_d1 : w_d0;
    assign o_bout = i_bin ? w_b1 : w_br[GROUP];

endmodule

// File: rtl/csla_div16.sv
// -----------------------------------------------------------------------------
// csla_div16
// Sequential unsigned restoring divider, one quotient bit per clock. The
// trial subtraction runs through a chain of 4-bit borrow-select groups.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of csla_div16_if (start/operands in,
//           busy/done/quotient/remainder/div_by_zero out)
// quotient/remainder are the live Q/R registers; they are meaningful from
// the done cycle until the next accepted start.
// -----------------------------------------------------------------------------
module csla_div16
    import csla_div_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    csla_div16_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned NG = WIDTH / GROUP;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz;

    logic             w_accept;
    logic             w_zero_div;
    logic             w_last;
    logic             w_msb;
    logic [WIDTH-1:0] w_r_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_bchain [0:NG];
    logic             w_take;

    // start is honoured in IDLE and DONE; ignored while iterating.
    assign w_accept   = bus.start && (r_state != RUN);
    assign w_zero_div = (bus.divisor == '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // {msb, R, Q} <= {R, Q} << 1
    assign w_msb  = r_r[WIDTH-1];
    assign w_r_sh = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_q_sh = {r_q[WIDTH-2:0], 1'b0};

    assign w_bchain[0] = 1'b0;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        group4_sub u_sub (
            .i_a    (w_r_sh[g*GROUP +: GROUP]),
            .i_b    (r_d[g*GROUP +: GROUP]),
            .i_bin  (w_bchain[g]),
            .o_diff (w_diff[g*GROUP +: GROUP]),
            .o_bout (w_bchain[g+1])
        );
    end

    // A shifted-out msb means the true remainder exceeds WIDTH bits, so the
    // subtraction always fits even though the WIDTH-bit borrow says otherwise.
    assign w_take = w_msb | ~w_bchain[NG];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = w_zero_div ? DONE : RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (bus.start) w_next = w_zero_div ? DONE : RUN;
                else           w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_d   <= bus.divisor;
                r_cnt <= '0;
                if (w_zero_div) begin
                    r_q   <= '1;
                    r_r   <= bus.dividend;
                    r_dbz <= 1'b1;
                end else begin
                    r_q   <= bus.dividend;
                    r_r   <= '0;
                    r_dbz <= 1'b0;
                end
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_take) begin
                    r_r <= w_diff;
                    r_q <= {w_q_sh[WIDTH-1:1], 1'b1};
                end else begin
                    r_r <= w_r_sh;
                    r_q <= w_q_sh;
                end
            end
        end
    end

    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_csla_div16.sv
// -----------------------------------------------------------------------------
// tb_csla_div16
// Self-checking bench for csla_div16: directed table, hand-written
// multi-cycle sequences (ignored start, back-to-back, mid-run reset) and
// random operand pairs checked against integer / and %.
// -----------------------------------------------------------------------------
module tb_csla_div16;

    localparam int unsigned W       = 16;
    localparam int          NORMLAT = 16;  // edges from accept to done
    localparam int          TIMEOUT = 40;

    logic clk;
    logic rst_n;

    csla_div16_if #(.WIDTH(W)) bus ();

    csla_div16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int n_done_seen;
    int n_done_exp;

    always @(negedge clk) if (bus.done === 1'b1) n_done_seen++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; lat = edges after the accepting edge, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        if (bus.done === 1'b1) begin
            lat = 0;
        end else begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                tick();
                if (bus.done === 1'b1) begin
                    lat = i;
                    break;
                end
            end
        end
    endtask

    // Drive one request; returns busy right after the accepting edge and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic busy_after, output int lat);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        busy_after   = bus.busy;
        wait_done(lat);
    endtask

    initial begin
        logic         busy_a;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_cmp = 0; n_fail = 0; n_done_seen = 0; n_done_exp = 0;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0};
        vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000, 1'b0};
        vecs[2]  = '{16'h8000,  16'hFFFF,   16'h0000,   16'h8000, 1'b0};
        vecs[3]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1};
        vecs[4]  = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0};
        vecs[5]  = '{16'd7,     16'd7,      16'd1,      16'd0,    1'b0};
        vecs[6]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0};
        vecs[7]  = '{16'd65535, 16'd256,    16'd255,    16'd255,  1'b0};
        vecs[8]  = '{16'd12345, 16'd123,    16'd100,    16'd45,   1'b0};
        vecs[9]  = '{16'd1,     16'd2,      16'd0,      16'd1,    1'b0};
        vecs[10] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,    1'b1};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        tick(); tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_dbz",  32'(bus.div_by_zero), 32'd0);
        chk("reset_q",    32'(bus.quotient), 32'd0);
        chk("reset_r",    32'(bus.remainder), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, busy_a, lat);
            n_done_exp++;
            chk($sformatf("v%0d_busy", i), 32'(busy_a), vecs[i].dz ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].dz ? 32'd0 : 32'(NORMLAT));
            chk($sformatf("v%0d_q", i), 32'(bus.quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i), 32'(bus.remainder), 32'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dz));
            chk($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
            tick();
        end

        // Start during RUN is ignored; then back-to-back start in the done cycle
        bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd2;
        tick();
        bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        n_done_exp++;
        chk("ign_lat", 32'(lat), 32'(NORMLAT - 4));
        chk("ign_q", 32'(bus.quotient), 32'd10);
        chk("ign_r", 32'(bus.remainder), 32'd0);
        run_op(16'd9, 16'd2, busy_a, lat);
        n_done_exp++;
        chk("b2b_busy", 32'(busy_a), 32'd1);
        chk("b2b_lat", 32'(lat), 32'(NORMLAT));
        chk("b2b_q", 32'(bus.quotient), 32'd4);
        chk("b2b_r", 32'(bus.remainder), 32'd1);
        tick();
        chk("b2b_done_pulse", 32'(bus.done), 32'd0);
        tick();

        // Reset in the middle of an operation aborts it
        bus.start = 1'b1; bus.dividend = 16'd60000; bus.divisor = 16'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q",    32'(bus.quotient), 32'd0);
        chk("rst_r",    32'(bus.remainder), 32'd0);
        tick(); tick();
        chk("rst_hold_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op(16'd60000, 16'd3, busy_a, lat);
        n_done_exp++;
        chk("post_rst_lat", 32'(lat), 32'(NORMLAT));
        chk("post_rst_q", 32'(bus.quotient), 32'd20000);
        chk("post_rst_r", 32'(bus.remainder), 32'd0);
        tick();

        // Random operand pairs with random idle gaps
        for (int n = 0; n < 2000; n++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 1) == 0) rb = W'($urandom_range(1, 255));
            else                           rb = W'($urandom_range(1, 65535));
            run_op(ra, rb, busy_a, lat);
            n_done_exp++;
            chk($sformatf("rnd%0d_q %0d/%0d", n, ra, rb), 32'(bus.quotient), 32'(ra / rb));
            chk($sformatf("rnd%0d_r %0d/%0d", n, ra, rb), 32'(bus.remainder), 32'(ra % rb));
            if (lat != NORMLAT) chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(NORMLAT));
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end

        tick(); tick();
        @(negedge clk);
        #1;
        chk("done_pulse_count", 32'(n_done_seen), 32'(n_done_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
